// File: rtl/count_32_seq_if.sv
// Bundle of the row sequencer's control, buffer-read and result signals.
// The master side is the sequencer. The slave side is the environment:
// the MVP control, the operand buffer feeding count_32, and the result consumer.
interface count_32_seq_if #(
    parameter int ADDR_W = 5,
    parameter int ROW_W  = 3,
    parameter int ACC_W  = 8
);
    logic              start;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [6:0]        h_plus_32;
    logic [6:0]        h_minus_32;
    logic              res_valid;
    logic              res_ready;
    logic [ROW_W-1:0]  res_row;
    logic [ACC_W-1:0]  res_plus;
    logic [ACC_W-1:0]  res_minus;
    logic [ACC_W:0]    res_diff;

    modport master (
        input  start, h_plus_32, h_minus_32, res_ready,
        output busy, done, rd_en, rd_addr,
        output res_valid, res_row, res_plus, res_minus, res_diff
    );

    modport slave (
        output start, h_plus_32, h_minus_32, res_ready,
        input  busy, done, rd_en, rd_addr,
        input  res_valid, res_row, res_plus, res_minus, res_diff
    );
endinterface

// File: rtl/count_32_seq.sv
// Row sequencer for the 32-lane ternary popcount datapath.
// It walks each row in CHUNKS reads. It sums the plus and minus counts that
// count_32 returns one cycle after each read. It then offers the row's totals
// on a valid/ready port and waits for them to be accepted before it moves to
// the next row.
module count_32_seq #(
    parameter int CHUNKS = 4,
    parameter int ROWS   = 8,
    parameter int ADDR_W = 5,
    parameter int ROW_W  = 3,
    parameter int ACC_W  = 8
) (
    input  logic           clk,
    input  logic           rst,
    count_32_seq_if.master bus
);
    localparam int                 CHUNK_W    = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(CHUNKS - 1);
    localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0]  CHUNKS_A   = ADDR_W'(CHUNKS);

    typedef enum logic [1:0] { IDLE, RUN, DRAIN, OUT } state_t;

    state_t             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [CHUNK_W-1:0] chunk_q, chunk_d;
    logic [ACC_W-1:0]   acc_plus_q, acc_plus_d;
    logic [ACC_W-1:0]   acc_minus_q, acc_minus_d;
    logic               samp_v_q, samp_v_d;
    logic               done_q, done_d;
    logic [ROW_W-1:0]   res_row_q, res_row_d;
    logic [ACC_W-1:0]   res_plus_q, res_plus_d;
    logic [ACC_W-1:0]   res_minus_q, res_minus_d;
    logic [ACC_W:0]     res_diff_q, res_diff_d;

    logic [ACC_W-1:0]   sum_plus, sum_minus;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic               handshake;

    // Fold in count_32's answer for last cycle's read; plain wrap-around adds, inputs taken as-is
    always_comb begin
        sum_plus  = acc_plus_q;
        sum_minus = acc_minus_q;
        if (samp_v_q) begin
            sum_plus  = acc_plus_q  + ACC_W'(bus.h_plus_32);
            sum_minus = acc_minus_q + ACC_W'(bus.h_minus_32);
        end
    end

    // Next-state, read issue and result capture; results live in their own registers so the port is register-driven and reads 0 outside OUT
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        chunk_d     = chunk_q;
        acc_plus_d  = sum_plus;
        acc_minus_d = sum_minus;
        done_d      = 1'b0;
        res_row_d   = res_row_q;
        res_plus_d  = res_plus_q;
        res_minus_d = res_minus_q;
        res_diff_d  = res_diff_q;
        rd_en       = 1'b0;
        rd_addr     = '0;
        handshake   = (state_q == OUT) && bus.res_ready;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    row_d       = '0;
                    chunk_d     = '0;
                    acc_plus_d  = '0;
                    acc_minus_d = '0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                rd_en   = 1'b1;
                rd_addr = ADDR_W'(row_q) * CHUNKS_A + ADDR_W'(chunk_q);
                if (chunk_q == LAST_CHUNK) begin
                    chunk_d = '0;
                    state_d = DRAIN;
                end else begin
                    chunk_d = chunk_q + 1'b1;
                end
            end
            DRAIN: begin
                res_row_d   = row_q;
                res_plus_d  = sum_plus;
                res_minus_d = sum_minus;
                res_diff_d  = {1'b0, sum_plus} - {1'b0, sum_minus};
                state_d     = OUT;
            end
            OUT: begin
                if (handshake) begin
                    acc_plus_d  = '0;
                    acc_minus_d = '0;
                    res_row_d   = '0;
                    res_plus_d  = '0;
                    res_minus_d = '0;
                    res_diff_d  = '0;
                    if (row_q == LAST_ROW) begin
                        row_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = RUN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        samp_v_d = rd_en;
    end

    // State register; reset abandons any row in flight without reporting it
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            chunk_q     <= '0;
            acc_plus_q  <= '0;
            acc_minus_q <= '0;
            samp_v_q    <= 1'b0;
            done_q      <= 1'b0;
            res_row_q   <= '0;
            res_plus_q  <= '0;
            res_minus_q <= '0;
            res_diff_q  <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            chunk_q     <= chunk_d;
            acc_plus_q  <= acc_plus_d;
            acc_minus_q <= acc_minus_d;
            samp_v_q    <= samp_v_d;
            done_q      <= done_d;
            res_row_q   <= res_row_d;
            res_plus_q  <= res_plus_d;
            res_minus_q <= res_minus_d;
            res_diff_q  <= res_diff_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.rd_en     = rd_en;
    assign bus.rd_addr   = rd_addr;
    assign bus.res_valid = (state_q == OUT);
    assign bus.res_row   = res_row_q;
    assign bus.res_plus  = res_plus_q;
    assign bus.res_minus = res_minus_q;
    assign bus.res_diff  = res_diff_q;
endmodule

// File: tb/tb_count_32_seq.sv
// Bench for the row sequencer. Instance dut uses CHUNKS=4 and ROWS=2, and
// behind it sits a modelled operand buffer. Instance dut1 uses CHUNKS=1 and
// ROWS=3, and it sees constant counts.
module tb_count_32_seq;
    localparam int CH    = 4;
    localparam int NROWS = 2;
    localparam int NADDR = CH * NROWS;

    typedef struct packed {
        logic [31:0] row;
        logic [31:0] plus;
        logic [31:0] minus;
        logic [31:0] diff;
    } res_t;

    typedef struct packed {
        logic [0:CH-1][6:0] hp;
        logic [0:CH-1][6:0] hm;
        logic [31:0]        ePlus;
        logic [31:0]        eMinus;
        logic [31:0]        eDiff;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   nCompared   = 0;
    int   nMismatched = 0;

    logic [6:0] memP [0:NADDR-1];
    logic [6:0] memM [0:NADDR-1];
    logic       pendEn   = 1'b0;
    logic [4:0] pendAddr = '0;

    res_t gotRes[$];
    int   gotAddr[$];
    int   doneCnt, busyAtDone, firstRdCyc, doneGap;
    int   latErr, gapErr, stableErr, overlapErr;

    vec_t vecs[6];

    count_32_seq_if #(.ADDR_W(5), .ROW_W(3), .ACC_W(8)) bus0 ();
    count_32_seq_if #(.ADDR_W(2), .ROW_W(2), .ACC_W(6)) bus1 ();

    count_32_seq #(.CHUNKS(4), .ROWS(2), .ADDR_W(5), .ROW_W(3), .ACC_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus0));

    count_32_seq #(.CHUNKS(1), .ROWS(3), .ADDR_W(2), .ROW_W(2), .ACC_W(6)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    // Operand buffer: a read seen in one cycle yields its counts in the next cycle.
    // At any other time the bus carries random garbage.
    always @(negedge clk) begin
        pendEn   = bus0.rd_en;
        pendAddr = bus0.rd_addr;
    end

    always @(posedge clk) begin
        #1;
        if (pendEn) begin
            bus0.h_plus_32  = memP[pendAddr[2:0]];
            bus0.h_minus_32 = memM[pendAddr[2:0]];
        end else begin
            bus0.h_plus_32  = 7'($urandom_range(0, 127));
            bus0.h_minus_32 = 7'($urandom_range(0, 127));
        end
    end

    // Watchdog so the run can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, want finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched + 1);
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference row result: plain sums of the buffer contents, modulo 2^8, and a 9-bit two's-complement difference
    function automatic res_t modelRow(input int r);
        int   sp = 0;
        int   sm = 0;
        res_t e;
        for (int c = 0; c < CH; c++) begin
            sp += int'(memP[r * CH + c]);
            sm += int'(memM[r * CH + c]);
        end
        sp = sp % 256;
        sm = sm % 256;
        e.row   = 32'(r);
        e.plus  = 32'(sp);
        e.minus = 32'(sm);
        e.diff  = 32'(sp - sm) & 32'h1FF;
        return e;
    endfunction

    // One full run on dut. readyMode: 0 = always ready, 1 = random, 2 = ten-cycle stall on first result
    task automatic applyStimulus(input int readyMode, input bit startNoise);
        int   cyc       = 0;
        int   rowStart  = 0;
        int   rdCount   = 0;
        int   holdLeft  = 10;
        int   lastHs    = -1;
        bit   prevValid = 0;
        bit   prevRd    = 0;
        bit   prevHsMid = 0;
        bit   prevStall = 0;
        bit   finished  = 0;
        bit   ready;
        res_t prevR     = '0;
        res_t curR;
        gotAddr.delete();
        gotRes.delete();
        doneCnt = 0; busyAtDone = -1; firstRdCyc = -1; doneGap = -1;
        latErr = 0; gapErr = 0; stableErr = 0; overlapErr = 0;
        bus0.start     = 1'b1;
        bus0.res_ready = 1'b0;
        tick();
        bus0.start = 1'b0;
        cyc = 1;
        while (!finished && cyc < 300) begin
            case (readyMode)
                0:       ready = 1'b1;
                1:       ready = 1'($urandom_range(0, 1));
                default: begin
                    if (bus0.res_valid && holdLeft > 0) begin
                        ready = 1'b0;
                        holdLeft--;
                    end else begin
                        ready = 1'b1;
                    end
                end
            endcase
            bus0.res_ready = ready;
            bus0.start     = startNoise && bus0.busy && ($urandom_range(0, 2) == 0);
            curR.row   = 32'(bus0.res_row);
            curR.plus  = 32'(bus0.res_plus);
            curR.minus = 32'(bus0.res_minus);
            curR.diff  = 32'(bus0.res_diff);
            if (bus0.rd_en) begin
                gotAddr.push_back(int'(bus0.rd_addr));
                if (firstRdCyc < 0) firstRdCyc = cyc;
                if (!prevRd) begin
                    rowStart = cyc;
                    rdCount  = 0;
                end
                rdCount++;
            end
            if (prevHsMid && !bus0.rd_en) gapErr++;
            if (bus0.res_valid && bus0.rd_en) overlapErr++;
            if (bus0.res_valid && !prevValid && ((cyc - rowStart) != CH + 1 || rdCount != CH)) latErr++;
            if (prevStall && (curR != prevR || !bus0.res_valid)) stableErr++;
            prevStall = bus0.res_valid && !ready;
            prevHsMid = bus0.res_valid && ready && (int'(bus0.res_row) != NROWS - 1);
            prevR     = curR;
            if (bus0.res_valid && ready) begin
                gotRes.push_back(curR);
                lastHs = cyc;
            end
            if (bus0.done) begin
                doneCnt++;
                busyAtDone = int'(bus0.busy);
                doneGap    = cyc - lastHs;
                finished   = 1;
            end
            prevValid = bus0.res_valid;
            prevRd    = bus0.rd_en;
            tick();
            cyc++;
        end
        bus0.start     = 1'b0;
        bus0.res_ready = 1'b0;
        checkOutput("run finished within budget", 32'(finished), 1);
        repeat (3) begin
            if (bus0.done) doneCnt++;
            tick();
        end
    endtask

    // Checks common to every run of dut
    task automatic checkRun(input string tag);
        checkOutput($sformatf("%s read count", tag), gotAddr.size(), NADDR);
        for (int i = 0; i < gotAddr.size() && i < NADDR; i++)
            checkOutput($sformatf("%s rd_addr #%0d", tag, i), gotAddr[i], i);
        checkOutput($sformatf("%s result count", tag), gotRes.size(), NROWS);
        checkOutput($sformatf("%s done pulses", tag), doneCnt, 1);
        checkOutput($sformatf("%s busy during done", tag), busyAtDone, 0);
        checkOutput($sformatf("%s done after last accept", tag), doneGap, 1);
        checkOutput($sformatf("%s first rd_en cycle", tag), firstRdCyc, 1);
        checkOutput($sformatf("%s res_valid latency errors", tag), latErr, 0);
        checkOutput($sformatf("%s next-row start errors", tag), gapErr, 0);
        checkOutput($sformatf("%s stall stability errors", tag), stableErr, 0);
        checkOutput($sformatf("%s read during OUT", tag), overlapErr, 0);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput($sformatf("%s busy", tag), 32'(bus0.busy), 0);
        checkOutput($sformatf("%s done", tag), 32'(bus0.done), 0);
        checkOutput($sformatf("%s rd_en", tag), 32'(bus0.rd_en), 0);
        checkOutput($sformatf("%s rd_addr", tag), 32'(bus0.rd_addr), 0);
        checkOutput($sformatf("%s res_valid", tag), 32'(bus0.res_valid), 0);
        checkOutput($sformatf("%s res_row", tag), 32'(bus0.res_row), 0);
        checkOutput($sformatf("%s res_plus", tag), 32'(bus0.res_plus), 0);
        checkOutput($sformatf("%s res_minus", tag), 32'(bus0.res_minus), 0);
        checkOutput($sformatf("%s res_diff", tag), 32'(bus0.res_diff), 0);
    endtask

    task automatic compareModel(input string tag);
        res_t e;
        for (int r = 0; r < NROWS && r < gotRes.size(); r++) begin
            e = modelRow(r);
            checkOutput($sformatf("%s row%0d res_row", tag, r), gotRes[r].row, e.row);
            checkOutput($sformatf("%s row%0d res_plus", tag, r), gotRes[r].plus, e.plus);
            checkOutput($sformatf("%s row%0d res_minus", tag, r), gotRes[r].minus, e.minus);
            checkOutput($sformatf("%s row%0d res_diff", tag, r), gotRes[r].diff, e.diff);
        end
    endtask

    // Abort row 1 at chunk 2 with reset, then show that a fresh run starts clean
    task automatic resetMidRow();
        int guard = 0;
        int stray = 0;
        for (int a = 0; a < NADDR; a++) begin
            memP[a] = 7'(a + 3);
            memM[a] = 7'(2 * a);
        end
        bus0.start     = 1'b1;
        bus0.res_ready = 1'b1;
        tick();
        bus0.start = 1'b0;
        while (!(bus0.rd_en && int'(bus0.rd_addr) == CH + 2) && guard < 40) begin
            tick();
            guard++;
        end
        checkOutput("reached row1 chunk2", 32'(guard < 40), 1);
        rst = 1'b1;
        tick();
        checkIdleOutputs("after mid-row reset");
        rst = 1'b0;
        bus0.res_ready = 1'b0;
        repeat (5) begin
            if (bus0.done || bus0.busy) stray++;
            tick();
        end
        checkOutput("no done/busy after mid-row reset", stray, 0);
        applyStimulus(0, 1'b0);
        checkRun("post-reset");
        compareModel("post-reset");
    endtask

    // CHUNKS=1, ROWS=3, every read counts +32 and -32
    task automatic runChunks1();
        int   cyc    = 0;
        int   dones  = 0;
        int   doneAt = -1;
        int   addrs[$];
        int   hsCyc[$];
        res_t res[$];
        res_t r;
        bus1.start     = 1'b1;
        bus1.res_ready = 1'b1;
        tick();
        bus1.start = 1'b0;
        cyc = 1;
        while (doneAt < 0 && cyc < 40) begin
            if (bus1.rd_en) addrs.push_back(int'(bus1.rd_addr));
            if (bus1.res_valid) begin
                r.row   = 32'(bus1.res_row);
                r.plus  = 32'(bus1.res_plus);
                r.minus = 32'(bus1.res_minus);
                r.diff  = 32'(bus1.res_diff);
                res.push_back(r);
                hsCyc.push_back(cyc);
            end
            if (bus1.done) begin
                dones++;
                doneAt = cyc;
            end
            tick();
            cyc++;
        end
        repeat (3) begin
            if (bus1.done) dones++;
            tick();
        end
        bus1.res_ready = 1'b0;
        checkOutput("c1 read count", addrs.size(), 3);
        for (int i = 0; i < addrs.size() && i < 3; i++)
            checkOutput($sformatf("c1 rd_addr #%0d", i), addrs[i], i);
        checkOutput("c1 result count", res.size(), 3);
        for (int i = 0; i < res.size() && i < 3; i++) begin
            checkOutput($sformatf("c1 row%0d res_row", i), res[i].row, i);
            checkOutput($sformatf("c1 row%0d res_plus", i), res[i].plus, 32);
            checkOutput($sformatf("c1 row%0d res_minus", i), res[i].minus, 32);
            checkOutput($sformatf("c1 row%0d res_diff", i), res[i].diff, 0);
            checkOutput($sformatf("c1 row%0d accept cycle", i), hsCyc[i], 3 * (i + 1));
        end
        checkOutput("c1 done pulses", dones, 1);
        checkOutput("c1 done cycle", doneAt, 10);
    endtask

    initial begin
        vecs[0] = '{hp: {7'd32, 7'd32, 7'd32, 7'd32}, hm: {7'd0, 7'd0, 7'd0, 7'd0},
                    ePlus: 128, eMinus: 0, eDiff: 32'h080};
        vecs[1] = '{hp: {7'd32, 7'd32, 7'd32, 7'd32}, hm: {7'd0, 7'd0, 7'd0, 7'd0},
                    ePlus: 128, eMinus: 0, eDiff: 32'h080};
        vecs[2] = '{hp: {7'd5, 7'd0, 7'd32, 7'd1}, hm: {7'd3, 7'd7, 7'd0, 7'd2},
                    ePlus: 38, eMinus: 12, eDiff: 32'd26};
        vecs[3] = '{hp: {7'd3, 7'd7, 7'd0, 7'd2}, hm: {7'd5, 7'd0, 7'd32, 7'd1},
                    ePlus: 12, eMinus: 38, eDiff: 32'h1E6};
        vecs[4] = '{hp: {7'd0, 7'd0, 7'd0, 7'd0}, hm: {7'd32, 7'd32, 7'd32, 7'd32},
                    ePlus: 0, eMinus: 128, eDiff: 32'h180};
        vecs[5] = '{hp: {7'd100, 7'd100, 7'd100, 7'd100}, hm: {7'd127, 7'd127, 7'd127, 7'd127},
                    ePlus: 144, eMinus: 252, eDiff: 32'h194};

        rst             = 1'b1;
        bus0.start      = 1'b0;
        bus0.res_ready  = 1'b0;
        bus1.start      = 1'b0;
        bus1.res_ready  = 1'b0;
        bus1.h_plus_32  = 7'd32;
        bus1.h_minus_32 = 7'd32;
        for (int a = 0; a < NADDR; a++) begin
            memP[a] = '0;
            memM[a] = '0;
        end
        tick();
        tick();
        checkIdleOutputs("reset");
        rst = 1'b0;
        tick();

        // Reset beats a simultaneous start
        rst        = 1'b1;
        bus0.start = 1'b1;
        tick();
        checkOutput("rst over start busy", 32'(bus0.busy), 0);
        rst        = 1'b0;
        bus0.start = 1'b0;
        tick();
        checkOutput("rst over start stays idle", 32'(bus0.busy), 0);

        // Table vectors: basic run, stall with start noise, random ready
        for (int p = 0; p < 3; p++) begin
            for (int r = 0; r < NROWS; r++)
                for (int c = 0; c < CH; c++) begin
                    memP[r * CH + c] = vecs[2 * p + r].hp[c];
                    memM[r * CH + c] = vecs[2 * p + r].hm[c];
                end
            applyStimulus((p == 0) ? 0 : ((p == 1) ? 2 : 1), p == 1);
            checkRun($sformatf("vec%0d", p));
            for (int r = 0; r < NROWS && r < gotRes.size(); r++) begin
                checkOutput($sformatf("vec%0d row%0d res_row", p, r), gotRes[r].row, r);
                checkOutput($sformatf("vec%0d row%0d res_plus", p, r), gotRes[r].plus, vecs[2 * p + r].ePlus);
                checkOutput($sformatf("vec%0d row%0d res_minus", p, r), gotRes[r].minus, vecs[2 * p + r].eMinus);
                checkOutput($sformatf("vec%0d row%0d res_diff", p, r), gotRes[r].diff, vecs[2 * p + r].eDiff);
            end
        end

        // Randomised runs against the reference model
        for (int t = 0; t < 15; t++) begin
            for (int a = 0; a < NADDR; a++) begin
                if ($urandom_range(0, 3) == 0) begin
                    memP[a] = 7'($urandom_range(0, 127));
                    memM[a] = 7'($urandom_range(0, 127));
                end else begin
                    memP[a] = 7'($urandom_range(0, 32));
                    memM[a] = 7'($urandom_range(0, 32));
                end
            end
            applyStimulus(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            checkRun($sformatf("rand%0d", t));
            compareModel($sformatf("rand%0d", t));
        end

        resetMidRow();
        runChunks1();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule

// File: doc/count_32_seq.md
# count_32_seq

Row sequencer for the 32-lane ternary popcount datapath (`count_32`). It walks a matrix row in 32-lane chunks and issues one read per cycle to the operand buffer feeding `count_32`. It accumulates the returned `h_plus_32`/`h_minus_32` over all chunks of the row and presents per-row plus, minus and signed difference results on a valid/ready port. It sits between the MVP top-level control (start/done) and the operand buffer plus `count_32` pair.

## Interface
- CHUNKS, 4, 32-lane chunks per row (≥1)
- ROWS, 8, rows per run (≥1)
- ADDR_W, 5, buffer address width; must be ≥ clog2(ROWS*CHUNKS)
- ROW_W, 3, row index width; must be ≥ clog2(ROWS)
- ACC_W, 8, accumulator width; must be ≥ clog2(32*CHUNKS+1)
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle run request; honoured only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last row's result is accepted
- rd_en  out  1  operand buffer read strobe; buffer data is valid one cycle later
- rd_addr  out  ADDR_W  row*CHUNKS + chunk
- h_plus_32  in  7  `count_32` positive count for the data read the previous cycle
- h_minus_32  in  7  `count_32` negative count for the data read the previous cycle
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts the result
- res_row  out  ROW_W  row index of the result
- res_plus  out  ACC_W  summed h_plus over the row
- res_minus  out  ACC_W  summed h_minus over the row
- res_diff  out  ACC_W+1  signed res_plus − res_minus

## Operation
- States: IDLE, RUN, DRAIN, OUT.
- IDLE: all outputs 0. When `start`=1, clear row, chunk and both accumulators, then go to RUN.
- RUN: `rd_en`=1 every cycle with `rd_addr` = row*CHUNKS+chunk. Chunk increments each cycle. The cycle that issues chunk CHUNKS−1 goes to DRAIN with chunk reset to 0.
- Sampling: `samp_v` is `rd_en` delayed by one register. When `samp_v`=1, acc_plus += h_plus_32 and acc_minus += h_minus_32. Addition is zero-extended modulo 2^ACC_W with no saturation. Inputs above 32 are added as-is.
- DRAIN: `rd_en`=0. Absorb the final chunk's sample, then go to OUT.
- OUT: `res_valid`=1. `res_row`/`res_plus`/`res_minus`/`res_diff` are driven directly from registers and stay stable until `res_ready`=1.
- On a handshake (res_valid & res_ready):
  - clear both accumulators;
  - if row = ROWS−1: pulse `done`, go to IDLE;
  - otherwise: row += 1, go to RUN.
- `start` outside IDLE is ignored and has no effect on the run in progress.
- `res_diff` is the sign-extended difference, range −32*CHUNKS to +32*CHUNKS.

## Timing
- Reset values: state=IDLE, busy=0, done=0, rd_en=0, rd_addr=0, res_valid=0, res_row=0, res_plus=0, res_minus=0, res_diff=0, accumulators=0, samp_v=0.
- `rst` wins over every other input. Reset mid-run drops the current row without a result or `done`; the next cycle is IDLE.
- `start` at edge N puts the first `rd_en` in cycle N+1.
- Per row: CHUNKS cycles of RUN + 1 DRAIN cycle + ≥1 OUT cycle. With `res_ready` held high, throughput is CHUNKS+2 cycles/row.
- `res_valid` rises CHUNKS+1 cycles after the row's first `rd_en`.
- `done` is asserted in the cycle after the final handshake. `busy` is 0 in that same cycle.
- No read is issued while in OUT. Back-pressure stalls the sequencer and never drops results.
- CHUNKS=1: RUN lasts exactly 1 cycle per row.

## Test plan
- Basic run, CHUNKS=4, ROWS=2, res_ready=1, all lanes +1 (h_plus_32=32, h_minus_32=0): two results with res_plus=128, res_minus=0, res_diff=+128, res_row=0 then 1. `done` pulses once. rd_addr sequence is 0..7.
- Mixed counts for one row: chunk values h_plus={5,0,32,1}, h_minus={3,7,0,2}. Required: res_plus=38, res_minus=12, res_diff=+26. Repeat with plus/minus swapped; required res_diff=−26.
- Back-pressure: hold res_ready=0 for 10 cycles in OUT. Required: rd_en stays 0, result stays stable, res_valid stays 1. The next row starts the cycle after res_ready=1.
- Start while busy: pulse start in RUN and in OUT. Required: addresses, results and the single `done` are unchanged.
- Reset mid-row: assert rst during chunk 2 of row 1. Required: next cycle all outputs 0 and no `done`. A new start restarts from rd_addr=0 with accumulators cleared.
- CHUNKS=1, ROWS=3 with h_plus_32=h_minus_32=32 on every read. Required: res_diff=0 for each row, 3 cycles/row with ready high, rd_addr 0,1,2.
